// File: rtl/tl45_fetch_queue_if.sv
// Prefetch/decode-facing signal bundle for the fetch queue.
// The master modport is the prefetch/decode side; the slave modport is the queue.
interface tl45_fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          i_pipe_flush;
  logic [31:0]   i_buf_pc;
  logic [31:0]   i_buf_inst;
  logic          o_pfetch_stall;
  logic          i_dec_stall;
  logic [31:0]   o_pc;
  logic [31:0]   o_inst;
  logic [AW:0]   o_count;

  modport master (
    output i_pipe_flush, i_buf_pc, i_buf_inst, i_dec_stall,
    input  o_pfetch_stall, o_pc, o_inst, o_count
  );

  modport slave (
    input  i_pipe_flush, i_buf_pc, i_buf_inst, i_dec_stall,
    output o_pfetch_stall, o_pc, o_inst, o_count
  );
endinterface

// File: rtl/tl45_fetch_queue.sv
// Instruction queue between prefetch and decode: DEPTH-entry FIFO of {pc, inst} pairs.
// Zero instruction words are bubbles and never enqueued; flush empties the queue.
module tl45_fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic               i_clk,
  input logic               i_reset,
  tl45_fetch_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [63:0]   mem_q [DEPTH];
  logic          push, pop;

  always_comb begin
    push    = (bus.i_buf_inst != 32'h0) && (count_q != FullCount) && !bus.i_pipe_flush;
    pop     = (count_q != '0) && !bus.i_dec_stall && !bus.i_pipe_flush;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.i_pipe_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated by count.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[tail_q] <= {bus.i_buf_pc, bus.i_buf_inst};
  end

  always_comb begin
    bus.o_pfetch_stall = (count_q == FullCount);
    bus.o_count        = count_q;
    if (count_q != '0) begin
      bus.o_pc   = mem_q[head_q][63:32];
      bus.o_inst = mem_q[head_q][31:0];
    end else begin
      bus.o_pc   = 32'h0;
      bus.o_inst = 32'h0;
    end
  end
endmodule

// File: tb/tb_tl45_fetch_queue.sv
// Directed bench for tl45_fetch_queue: a queue-based reference model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_tl45_fetch_queue;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;

  tl45_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  tl45_fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an ordered list of queued {pc, inst} entries.
  logic [63:0] mq[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else if (bus.i_pipe_flush) begin
      mq.delete();
    end else begin
      bit do_pop, do_push;
      do_pop  = (mq.size() != 0) && !bus.i_dec_stall;
      do_push = (bus.i_buf_inst != 32'h0) && (mq.size() < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({bus.i_buf_pc, bus.i_buf_inst});
    end
  end

  always @(negedge clk) begin
    logic [31:0] epc, einst;
    epc   = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
    einst = (mq.size() != 0) ? mq[0][31:0] : 32'h0;
    check("model_pc", bus.o_pc, epc);
    check("model_inst", bus.o_inst, einst);
    check("model_count", 32'(bus.o_count), 32'(mq.size()));
    check("model_stall", 32'(bus.o_pfetch_stall), 32'(mq.size() == DEPTH));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst);
    bus.i_buf_pc   = pc;
    bus.i_buf_inst = inst;
  endtask

  initial begin
    rst              = 1'b1;
    bus.i_pipe_flush = 1'b0;
    bus.i_dec_stall  = 1'b0;
    drive(32'h0, 32'h0);
    cyc();
    cyc();
    check("rst_count", 32'(bus.o_count), 32'd0);
    check("rst_pc", bus.o_pc, 32'h0);
    check("rst_inst", bus.o_inst, 32'h0);
    check("rst_stall", 32'(bus.o_pfetch_stall), 32'd0);
    rst = 1'b0;
    cyc();

    // Single push, visible next cycle, consumed the cycle after.
    drive(32'h100, 32'hA000_0001);
    cyc();
    drive(32'h0, 32'h0);
    check("single_pc", bus.o_pc, 32'h100);
    check("single_inst", bus.o_inst, 32'hA000_0001);
    check("single_count", 32'(bus.o_count), 32'd1);
    cyc();
    check("single_drain_inst", bus.o_inst, 32'h0);
    check("single_drain_count", 32'(bus.o_count), 32'd0);

    // Fill with decode stalled, hold a fifth word, then release.
    bus.i_dec_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(32'(4 * i), 32'hB000_0000 + 32'(i));
      cyc();
    end
    check("fill_count", 32'(bus.o_count), 32'd4);
    check("fill_stall", 32'(bus.o_pfetch_stall), 32'd1);
    drive(32'h10, 32'hB000_0004);
    cyc();
    check("full_hold_count", 32'(bus.o_count), 32'd4);
    check("full_head_pc", bus.o_pc, 32'h0);
    bus.i_dec_stall = 1'b0;
    cyc();
    check("rel_pc0", bus.o_pc, 32'h4);
    check("rel_count0", 32'(bus.o_count), 32'd3);
    check("rel_stall0", 32'(bus.o_pfetch_stall), 32'd0);
    cyc();
    drive(32'h0, 32'h0);
    check("rel_pc1", bus.o_pc, 32'h8);
    check("rel_count1", 32'(bus.o_count), 32'd3);
    cyc();
    check("rel_pc2", bus.o_pc, 32'hC);
    cyc();
    check("rel_pc3", bus.o_pc, 32'h10);
    check("rel_inst3", bus.o_inst, 32'hB000_0004);
    cyc();
    check("rel_empty", 32'(bus.o_count), 32'd0);

    // Two queued, then ten overlapped push/pop cycles across the pointer wrap.
    bus.i_dec_stall = 1'b1;
    drive(32'h20, 32'hC000_0000);
    cyc();
    drive(32'h24, 32'hC000_0001);
    cyc();
    bus.i_dec_stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(32'h28 + 32'(4 * k), 32'hC000_0002 + 32'(k));
      cyc();
      check("wrap_count", 32'(bus.o_count), 32'd2);
      check("wrap_pc", bus.o_pc, 32'h20 + 32'(4 * (k + 1)));
    end
    drive(32'h0, 32'h0);
    cyc();
    cyc();
    check("wrap_drained", 32'(bus.o_count), 32'd0);

    // Bubbles are never enqueued.
    bus.i_dec_stall = 1'b1;
    drive(32'h300, 32'hD000_0000);
    cyc();
    for (int k = 0; k < 3; k++) begin
      drive(32'h200, 32'h0);
      cyc();
      check("bubble_count", 32'(bus.o_count), 32'd1);
      check("bubble_pc", bus.o_pc, 32'h300);
    end
    bus.i_dec_stall = 1'b0;
    cyc();
    check("bubble_drain", 32'(bus.o_inst), 32'h0);

    // Flush with three queued and a valid word in the flush cycle.
    bus.i_dec_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h500 + 32'(4 * i), 32'hE000_0000 + 32'(i));
      cyc();
    end
    check("preflush_count", 32'(bus.o_count), 32'd3);
    bus.i_pipe_flush = 1'b1;
    drive(32'h50C, 32'hE000_0003);
    cyc();
    bus.i_pipe_flush = 1'b0;
    bus.i_dec_stall  = 1'b0;
    check("flush_count", 32'(bus.o_count), 32'd0);
    check("flush_inst", bus.o_inst, 32'h0);
    check("flush_stall", 32'(bus.o_pfetch_stall), 32'd0);
    drive(32'h400, 32'hF000_0000);
    cyc();
    drive(32'h0, 32'h0);
    check("postflush_pc", bus.o_pc, 32'h400);
    check("postflush_count", 32'(bus.o_count), 32'd1);
    cyc();

    // Asynchronous reset between edges at count 3.
    bus.i_dec_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h600 + 32'(4 * i), 32'h9000_0000 + 32'(i));
      cyc();
    end
    drive(32'h0, 32'h0);
    check("prerst_count", 32'(bus.o_count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async_count", 32'(bus.o_count), 32'd0);
    check("async_pc", bus.o_pc, 32'h0);
    check("async_inst", bus.o_inst, 32'h0);
    cyc();
    rst = 1'b0;
    bus.i_dec_stall = 1'b0;
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tl45_fetch_queue.md
Name: tl45_fetch_queue

Overview:
Instruction queue between the prefetch stage and decode. It captures each {pc, instruction} pair from the prefetch output buffer into a DEPTH-entry FIFO and presents the oldest entry to decode. It decouples decode stalls from the Wishbone fetch timing, and back-pressures prefetch through its pipe-stall input. On a pipeline flush it drops all queued entries.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2.
AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
i_clk  in  1  system clock; all state changes on the rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_pipe_flush  in  1  discard all entries; the integrator drives it as the OR of flush and new-PC.
i_buf_pc  in  32  PC from the prefetch buffer.
i_buf_inst  in  32  instruction from the prefetch buffer; 32'h0 means bubble.
o_pfetch_stall  out  1  to the prefetch i_pipe_stall; high when the queue is full.
i_dec_stall  in  1  decode is stalled; hold the head entry.
o_pc  out  32  head entry PC; 0 when empty.
o_inst  out  32  head entry instruction; 0 when empty.
o_count  out  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, i_reset=1): head and tail pointers = 0, count = 0, o_pfetch_stall = 0, o_pc = 0, o_inst = 0, o_count = 0. Storage contents are don't-care.
- Entry is valid when i_buf_inst != 0. Instruction word 0 is reserved as a bubble and is never enqueued.
- push = valid input && count != DEPTH. The entry is written at tail and tail increments mod DEPTH.
- o_pfetch_stall = (count == DEPTH), combinational from registered count.
  - Prefetch holds its buffer while stalled, so nothing is lost.
  - Prefetch presents a word for one cycle when not stalled. push must capture it in that cycle.
- pop = count != 0 && !i_dec_stall. Head increments mod DEPTH.
- Output timing:
  - o_pc/o_inst present storage[head] whenever count != 0, otherwise 0.
  - Decode consumes the head in any cycle where o_inst != 0 and i_dec_stall = 0.
  - Latency: a word pushed into an empty queue appears on o_pc/o_inst in the next cycle.
  - No combinational input-to-output bypass.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- When full, push is blocked even if a pop occurs in the same cycle. The stall deasserts the cycle after the pop.
- Pointer wrap: natural mod-DEPTH wrap at DEPTH-1 -> 0. The full/empty decision uses count only, never a pointer compare.
- i_pipe_flush (synchronous, priority over push/pop):
  - Next cycle: count = 0, head = tail = 0, o_pc = o_inst = 0, o_pfetch_stall = 0.
  - A valid input presented in the flush cycle is discarded.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. Deassertion is synchronised externally.
- Internal state: OCCUPANCY is implicit in count (EMPTY: count=0; PARTIAL; FULL: count=DEPTH). No other FSM.
- Formal properties:
  - count <= DEPTH.
  - count == (tail - head) mod DEPTH, except when count is 0 or DEPTH.
  - o_inst == 0 iff count == 0 (given no zero words are stored).
  - No push while o_pfetch_stall is high.

Test Plan:
- Reset then single push: i_buf_pc=0x100, i_buf_inst=0xA0000001 for one cycle, i_dec_stall=0 -> next cycle o_pc=0x100, o_inst=0xA0000001, o_count=1; one cycle later o_inst=0, o_count=0.
- Fill, DEPTH=4, i_dec_stall=1: push pc 0x0,0x4,0x8,0xC -> o_count=4 and o_pfetch_stall=1; a fifth word at 0x10 is held by prefetch and not enqueued. Release stall -> outputs 0x0,0x4,0x8,0xC in order, then 0x10.
- Simultaneous push/pop at count=2 -> o_count stays 2 and order is preserved. Run 10 consecutive words through to exercise pointer wrap; PCs emerge strictly increasing by 4.
- Bubble filter: i_buf_inst=0 with i_buf_pc=0x200 for 3 cycles -> o_count unchanged, nothing emitted.
- Flush with 3 queued plus a valid input in the same cycle -> next cycle o_count=0, o_inst=0, o_pfetch_stall=0; the next push at 0x400 emerges first.
- Async reset mid-fill: assert i_reset between clock edges at count=3 -> o_count=0, o_pc=0, o_inst=0 before the next edge.
